// File: rtl/stack_sequencer.sv
// Stack sequencer: turns decoded push/pop/call/ret ops into single-word memory transactions
// against a downward-growing stack held in external memory.
module stack_sequencer #(
   parameter logic [15:0] SP_TOP   = 16'h0100,
   parameter logic [15:0] SP_LIMIT = 16'h00FC
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        op_valid_i,
   input  logic [1:0]  op_code_i,
   input  logic [15:0] op_wdata_i,
   output logic        op_ready_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [15:0] mem_addr_o,
   output logic [15:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [15:0] mem_rdata_i,
   output logic        done_o,
   output logic        rd_valid_o,
   output logic [15:0] rd_data_o,
   output logic [15:0] sp_o,
   output logic        overflow_o,
   output logic        underflow_o
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWr   = 2'd1,
      StRd   = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] sp_q, sp_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [15:0] mem_wdata_q, mem_wdata_d;
   logic [15:0] rd_data_q, rd_data_d;
   logic        done_q, done_d;
   logic        rd_valid_q, rd_valid_d;
   logic        overflow_q, overflow_d;
   logic        underflow_q, underflow_d;

   logic        accept;
   logic        is_pop;
   logic        stack_full;
   logic        stack_empty;

   assign op_ready_o  = (state_q == StIdle);
   assign accept      = op_valid_i && op_ready_o;
   // op_code bit 0 separates pop/ret from push/call; call/ret behave exactly like push/pop.
   assign is_pop      = op_code_i[0];
   assign stack_full  = (sp_q == SP_LIMIT);
   assign stack_empty = (sp_q == SP_TOP);

   always_comb begin
      state_d     = state_q;
      sp_d        = sp_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rd_data_d   = rd_data_q;
      done_d      = 1'b0;
      rd_valid_d  = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (!is_pop) begin
                  if (stack_full) begin
                     overflow_d = 1'b1;
                  end else begin
                     state_d     = StWr;
                     mem_req_d   = 1'b1;
                     mem_we_d    = 1'b1;
                     mem_addr_d  = sp_q - 16'd1;
                     mem_wdata_d = op_wdata_i;
                  end
               end else begin
                  if (stack_empty) begin
                     underflow_d = 1'b1;
                  end else begin
                     state_d    = StRd;
                     mem_req_d  = 1'b1;
                     mem_we_d   = 1'b0;
                     mem_addr_d = sp_q;
                  end
               end
            end
         end
         StWr: begin
            if (mem_ack_i) begin
               state_d   = StIdle;
               mem_req_d = 1'b0;
               sp_d      = sp_q - 16'd1;
               done_d    = 1'b1;
            end
         end
         StRd: begin
            if (mem_ack_i) begin
               state_d    = StIdle;
               mem_req_d  = 1'b0;
               sp_d       = sp_q + 16'd1;
               rd_data_d  = mem_rdata_i;
               done_d     = 1'b1;
               rd_valid_d = 1'b1;
            end
         end
         default: begin
            state_d   = StIdle;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // Reset abandons any in-flight transaction; a late ack then lands in idle and is ignored.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         sp_q        <= SP_TOP;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 16'h0000;
         mem_wdata_q <= 16'h0000;
         rd_data_q   <= 16'h0000;
         done_q      <= 1'b0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sp_q        <= sp_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rd_data_q   <= rd_data_d;
         done_q      <= done_d;
         rd_valid_q  <= rd_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign rd_data_o   = rd_data_q;
   assign sp_o        = sp_q;
   assign done_o      = done_q;
   assign rd_valid_o  = rd_valid_q;
   assign overflow_o  = overflow_q;
   assign underflow_o = underflow_q;

endmodule
